// File: rtl/serial_byte_assembler.sv
// rtl/serial_byte_assembler.sv - serial-to-parallel byte assembler with header flag and framing error
// Collects data_ena-qualified serial bits into bytes and pulses byte_assembled per completed byte.
module serial_byte_assembler #(
    parameter logic [7:0] HDR_A     = 8'hA5,
    parameter logic [7:0] HDR_B     = 8'hC3,
    parameter bit         MSB_FIRST = 1'b1
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       serial_data,
    input  logic       data_ena,
    output logic [7:0] data_byte,
    output logic       byte_assembled,
    output logic       a5_or_c3,
    output logic       frame_err
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_byte_q, data_byte_d;
    logic        byte_assembled_q, byte_assembled_d;
    logic        a5_or_c3_q, a5_or_c3_d;
    logic        frame_err_q, frame_err_d;

    logic [7:0]  shift_next;
    logic [7:0]  first_bit;
    logic        is_header;

    // Shift register contents including the bit sampled on this edge.
    always_comb begin
        shift_next = 8'h00;
        first_bit  = 8'h00;
        if (MSB_FIRST) begin
            shift_next = {shift_q[6:0], serial_data};
            first_bit  = {7'b0, serial_data};
        end else begin
            shift_next = {serial_data, shift_q[7:1]};
            first_bit  = {serial_data, 7'b0};
        end
    end

    assign is_header = (shift_next == HDR_A) || (shift_next == HDR_B);

    always_comb begin
        state_d          = state_q;
        bit_cnt_d        = bit_cnt_q;
        shift_d          = shift_q;
        data_byte_d      = data_byte_q;
        byte_assembled_d = 1'b0;
        a5_or_c3_d       = 1'b0;
        frame_err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_ena) begin
                    state_d   = SHIFT;
                    shift_d   = first_bit;
                    bit_cnt_d = 3'd1;
                end
            end
            SHIFT: begin
                if (data_ena) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    // Eighth bit: publish the byte and stay in SHIFT for back-to-back data.
                    if (bit_cnt_q == 3'd7) begin
                        data_byte_d      = shift_next;
                        byte_assembled_d = 1'b1;
                        a5_or_c3_d       = is_header;
                    end
                end else begin
                    state_d     = IDLE;
                    bit_cnt_d   = 3'd0;
                    shift_d     = 8'h00;
                    frame_err_d = (bit_cnt_q != 3'd0);
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = 3'd0;
                shift_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q          <= IDLE;
            bit_cnt_q        <= 3'd0;
            shift_q          <= 8'h00;
            data_byte_q      <= 8'h00;
            byte_assembled_q <= 1'b0;
            a5_or_c3_q       <= 1'b0;
            frame_err_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            bit_cnt_q        <= bit_cnt_d;
            shift_q          <= shift_d;
            data_byte_q      <= data_byte_d;
            byte_assembled_q <= byte_assembled_d;
            a5_or_c3_q       <= a5_or_c3_d;
            frame_err_q      <= frame_err_d;
        end
    end

    assign data_byte      = data_byte_q;
    assign byte_assembled = byte_assembled_q;
    assign a5_or_c3       = a5_or_c3_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_serial_byte_assembler.sv
// tb/tb_serial_byte_assembler.sv - directed self-checking bench for serial_byte_assembler
module tb_serial_byte_assembler;

    logic       clk_50 = 1'b0;
    logic       reset;
    logic       serial_data;
    logic       data_ena;
    logic [7:0] data_byte;
    logic       byte_assembled;
    logic       a5_or_c3;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    serial_byte_assembler dut (
        .clk_50         (clk_50),
        .reset          (reset),
        .serial_data    (serial_data),
        .data_ena       (data_ena),
        .data_byte      (data_byte),
        .byte_assembled (byte_assembled),
        .a5_or_c3       (a5_or_c3),
        .frame_err      (frame_err)
    );

    always #5 clk_50 = ~clk_50;

    // Drive on the falling edge, observe 1 ns after the following rising edge.
    task automatic step(input logic ena, input logic bit_in, input logic rst);
        @(negedge clk_50);
        reset       = rst;
        data_ena    = ena;
        serial_data = bit_in;
        @(posedge clk_50);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(i[0], 1'b1, 1'b1);
            checks++;
            if ({data_byte, byte_assembled, a5_or_c3, frame_err} !== 11'h0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got byte=%h ba=%b hdr=%b fe=%b want all 0",
                         i, data_byte, byte_assembled, a5_or_c3, frame_err);
            end
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_byte(input logic [7:0] val, input logic exp_hdr, input string name);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, val[7-k], 1'b0);
            checks++;
            if (k < 7) begin
                if (byte_assembled !== 1'b0 || frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_pulse bit %0d: got ba=%b fe=%b want 0 0",
                             name, k, byte_assembled, frame_err);
                end
            end else begin
                if (byte_assembled !== 1'b1 || data_byte !== val || a5_or_c3 !== exp_hdr) begin
                    errors++;
                    $display("FAIL %s complete: got ba=%b byte=%h hdr=%b want 1 %h %b",
                             name, byte_assembled, data_byte, a5_or_c3, val, exp_hdr);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (byte_assembled !== 1'b0 || a5_or_c3 !== 1'b0 || frame_err !== 1'b0 || data_byte !== val) begin
            errors++;
            $display("FAIL %s after: got ba=%b hdr=%b fe=%b byte=%h want 0 0 0 %h",
                     name, byte_assembled, a5_or_c3, frame_err, data_byte, val);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5];
        logic [7:0] cur;
        bytes = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 40; i++) begin
            cur = bytes[i / 8];
            step(1'b1, cur[7 - (i % 8)], 1'b0);
            checks++;
            if ((i % 8) == 7) begin
                if (byte_assembled !== 1'b1 || data_byte !== cur || a5_or_c3 !== (i == 7)) begin
                    errors++;
                    $display("FAIL b2b pulse bit %0d: got ba=%b byte=%h hdr=%b want 1 %h %b",
                             i, byte_assembled, data_byte, a5_or_c3, cur, (i == 7));
                end
            end else if (byte_assembled !== 1'b0 || a5_or_c3 !== 1'b0 || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b idle bit %0d: got ba=%b hdr=%b fe=%b want 0 0 0",
                         i, byte_assembled, a5_or_c3, frame_err);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (frame_err !== 1'b0 || byte_assembled !== 1'b0) begin
            errors++;
            $display("FAIL b2b boundary: got fe=%b ba=%b want 0 0", frame_err, byte_assembled);
        end
    endtask

    task automatic test_frame_err();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || byte_assembled !== 1'b0 || data_byte !== 8'h44) begin
            errors++;
            $display("FAIL frame_err pulse: got fe=%b ba=%b byte=%h want 1 0 44",
                     frame_err, byte_assembled, data_byte);
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err width: got fe=%b want 0", frame_err);
        end
        test_byte(8'h5A, 1'b0, "after_frame_err");
    endtask

    task automatic test_reset_mid_byte();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if ({data_byte, byte_assembled, a5_or_c3, frame_err} !== 11'h0) begin
            errors++;
            $display("FAIL reset_mid_byte: got byte=%h ba=%b hdr=%b fe=%b want all 0",
                     data_byte, byte_assembled, a5_or_c3, frame_err);
        end
        test_byte(8'hA5, 1'b1, "after_reset");
    endtask

    initial begin
        reset       = 1'b1;
        data_ena    = 1'b0;
        serial_data = 1'b0;
        test_reset();
        test_byte(8'hA5, 1'b1, "byte_a5");
        test_byte(8'h3C, 1'b0, "byte_3c");
        test_byte(8'hC3, 1'b1, "byte_c3");
        test_back_to_back();
        test_frame_err();
        test_reset_mid_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
